// File: rtl/l2dr_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : l2dr_rr_arb
//  Description : Round-robin arbiter sharing the L2-to-directory request
//                channel among NREQ L2 data slices. The winner of each
//                cycle is pushed, tagged with its slice index, into a
//                2-entry output queue.
//                Optional build macro L2DR_ARB_FIXPRIO_EN selects fixed
//                priority (lowest index wins) and removes the round-robin
//                pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
module l2dr_rr_arb #(
    parameter int NREQ = 4,
    parameter int DW   = 64,
    parameter int SW   = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     in_valid,
    output logic [NREQ-1:0]     in_retry,
    input  logic [NREQ*DW-1:0]  in_data,
    output logic                out_valid,
    input  logic                out_retry,
    output logic [DW-1:0]       out_data,
    output logic [SW-1:0]       out_src
);

    localparam logic [1:0] c_QDEPTH = 2'd2;

    // Queue storage and bookkeeping
    logic [DW-1:0]   r_q_data [2];
    logic [SW-1:0]   r_q_src  [2];
    logic            r_head;
    logic            r_tail;
    logic [1:0]      r_count;

    logic            w_space;
    logic            w_gnt_vld;
    logic [SW-1:0]   w_gnt_idx;
    logic [NREQ-1:0] w_gnt_oh;
    logic [DW-1:0]   w_gnt_data;
    logic            w_push;
    logic            w_pop;

`ifndef L2DR_ARB_FIXPRIO_EN
    logic [SW-1:0]   r_ptr;
    logic [SW:0]     w_scan;
`endif

    // Pick the first valid slice in scan order (from r_ptr, or from 0 in fixed-priority builds)
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
`ifndef L2DR_ARB_FIXPRIO_EN
        w_scan    = '0;
`endif
        for (int k = 0; k < NREQ; k++) begin
`ifdef L2DR_ARB_FIXPRIO_EN
            if (!w_gnt_vld && in_valid[k]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = SW'(k);
            end
`else
            w_scan = {1'b0, r_ptr} + (SW+1)'(k);
            if (w_scan >= (SW+1)'(NREQ)) begin
                w_scan = w_scan - (SW+1)'(NREQ);
            end
            if (!w_gnt_vld && in_valid[w_scan[SW-1:0]]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_scan[SW-1:0];
            end
`endif
        end
    end

    // Space depends only on registered count; reset forces every slice to retry
    assign w_space    = reset && (r_count < c_QDEPTH);
    assign w_push     = w_space && w_gnt_vld;
    assign w_gnt_oh   = w_push ? (NREQ'(1) << w_gnt_idx) : '0;
    assign in_retry   = ~w_gnt_oh;
    assign w_gnt_data = in_data[w_gnt_idx*DW +: DW];

    assign out_valid  = (r_count != 2'd0);
    assign out_data   = r_q_data[r_head];
    assign out_src    = r_q_src[r_head];
    assign w_pop      = out_valid && !out_retry;

    // Queue push/pop and occupancy tracking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= 2'd0;
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            for (int e = 0; e < 2; e++) begin
                r_q_data[e] <= '0;
                r_q_src[e]  <= '0;
            end
        end else begin
            if (w_push) begin
                r_q_data[r_tail] <= w_gnt_data;
                r_q_src[r_tail]  <= w_gnt_idx;
                r_tail           <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifndef L2DR_ARB_FIXPRIO_EN
    // Round-robin pointer moves just past the slice that was accepted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (w_push) begin
            r_ptr <= (w_gnt_idx == SW'(NREQ-1)) ? '0 : w_gnt_idx + SW'(1);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_l2dr_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_l2dr_rr_arb
//  Description : Directed self-checking bench for l2dr_rr_arb (NREQ=4, DW=64)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_l2dr_rr_arb;

    localparam int NREQ = 4;
    localparam int DW   = 64;
    localparam int SW   = 2;

    logic                clk;
    logic                reset;
    logic [NREQ-1:0]     in_valid;
    logic [NREQ-1:0]     in_retry;
    logic [NREQ*DW-1:0]  in_data;
    logic                out_valid;
    logic                out_retry;
    logic [DW-1:0]       out_data;
    logic [SW-1:0]       out_src;

    int n_checks = 0;
    int n_errors = 0;

    l2dr_rr_arb #(.NREQ(NREQ), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_retry  (in_retry),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_retry (out_retry),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        in_valid  = '0;
        out_retry = 1'b0;
        in_data   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic set_data(input int s, input logic [DW-1:0] v);
        in_data[s*DW +: DW] = v;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        in_valid  = 4'b1111;
        out_retry = 1'b0;
        in_data   = '1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++;
        if (out_data !== 64'h0) begin n_errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        n_checks++;
        if (out_src !== 2'd0) begin n_errors++; $display("FAIL reset_out_src: got %0d expected 0", out_src); end
        n_checks++;
        if (in_retry !== 4'b1111) begin n_errors++; $display("FAIL reset_in_retry: got %b expected 1111", in_retry); end
        in_valid = '0;
        in_data  = '0;
    endtask

    task automatic test_single();
        do_reset();
        set_data(2, 64'hA5);
        in_valid = 4'b0100;
        #1;
        n_checks++;
        if (in_retry !== 4'b1011) begin n_errors++; $display("FAIL single_grant: got %b expected 1011", in_retry); end
        step();
        in_valid = '0;
        #1;
        n_checks++;
        if (out_valid !== 1'b1) begin n_errors++; $display("FAIL single_out_valid: got %b expected 1", out_valid); end
        n_checks++;
        if (out_data !== 64'hA5) begin n_errors++; $display("FAIL single_out_data: got %h expected a5", out_data); end
        n_checks++;
        if (out_src !== 2'd2) begin n_errors++; $display("FAIL single_out_src: got %0d expected 2", out_src); end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL single_drain: got %b expected 0", out_valid); end
        // ptr is now 3, so with everyone requesting slice 3 wins
        in_valid = 4'b1111;
        #1;
        n_checks++;
        if (in_retry !== 4'b0111) begin n_errors++; $display("FAIL single_ptr_next: got %b expected 0111", in_retry); end
        in_valid = '0;
    endtask

    task automatic test_fairness();
        int acc [NREQ];
        logic [NREQ-1:0] exp_retry;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            acc[i] = 0;
            set_data(i, 64'h100 + 64'(i));
        end
        in_valid = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            #1;
            exp_retry = ~(4'b0001 << (n % 4));
            n_checks++;
            if (in_retry !== exp_retry) begin n_errors++; $display("FAIL fair_retry[%0d]: got %b expected %b", n, in_retry, exp_retry); end
            for (int i = 0; i < NREQ; i++) begin
                if (in_valid[i] && !in_retry[i]) acc[i]++;
            end
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_src !== 2'(n % 4) || out_data !== 64'h100 + 64'(n % 4)) begin
                n_errors++;
                $display("FAIL fair_out[%0d]: got v=%b src=%0d data=%h expected v=1 src=%0d data=%h",
                         n, out_valid, out_src, out_data, n % 4, 64'h100 + 64'(n % 4));
            end
        end
        in_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            n_checks++;
            if (acc[i] !== 2) begin n_errors++; $display("FAIL fair_count[%0d]: got %0d expected 2", i, acc[i]); end
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL fair_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < NREQ; i++) set_data(i, 64'h200 + 64'(i));
        out_retry = 1'b1;
        in_valid  = 4'b1111;
        #1;
        n_checks++;
        if (in_retry !== 4'b1110) begin n_errors++; $display("FAIL bp_grant0: got %b expected 1110", in_retry); end
        step();
        n_checks++;
        if (in_retry !== 4'b1101) begin n_errors++; $display("FAIL bp_grant1: got %b expected 1101", in_retry); end
        step();
        n_checks++;
        if (in_retry !== 4'b1111) begin n_errors++; $display("FAIL bp_full: got %b expected 1111", in_retry); end
        for (int c = 0; c < 5; c++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 64'h200 || in_retry !== 4'b1111) begin
                n_errors++;
                $display("FAIL bp_hold[%0d]: got v=%b src=%0d data=%h retry=%b expected v=1 src=0 data=200 retry=1111",
                         c, out_valid, out_src, out_data, in_retry);
            end
        end
        out_retry = 1'b0;
        in_valid  = '0;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== 64'h201) begin
            n_errors++;
            $display("FAIL bp_drain1: got v=%b src=%0d data=%h expected v=1 src=1 data=201", out_valid, out_src, out_data);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL bp_empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_retry = 1'b0;
        in_valid  = 4'b1000;
        for (int n = 0; n < 5; n++) begin
            set_data(3, 64'h300 + 64'(n));
            #1;
            n_checks++;
            if (in_retry !== 4'b0111) begin n_errors++; $display("FAIL b2b_retry[%0d]: got %b expected 0111", n, in_retry); end
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_src !== 2'd3 || out_data !== 64'h300 + 64'(n)) begin
                n_errors++;
                $display("FAIL b2b_out[%0d]: got v=%b src=%0d data=%h expected v=1 src=3 data=%h",
                         n, out_valid, out_src, out_data, 64'h300 + 64'(n));
            end
        end
        in_valid = '0;
        step();
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < NREQ; i++) set_data(i, 64'h400 + 64'(i));
        out_retry = 1'b1;
        in_valid  = 4'b1111;
        step();
        step();
        n_checks++;
        if (out_valid !== 1'b1 || in_retry !== 4'b1111) begin
            n_errors++;
            $display("FAIL ar_full: got v=%b retry=%b expected v=1 retry=1111", out_valid, in_retry);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_retry !== 4'b1111 || out_data !== 64'h0) begin
            n_errors++;
            $display("FAIL ar_immediate: got v=%b retry=%b data=%h expected v=0 retry=1111 data=0",
                     out_valid, in_retry, out_data);
        end
        in_valid  = '0;
        out_retry = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        // ptr back at 0: slice 0 beats slice 2 (stale ptr 2 would pick slice 2)
        in_valid = 4'b0101;
        #1;
        n_checks++;
        if (in_retry !== 4'b1110) begin n_errors++; $display("FAIL ar_ptr0: got %b expected 1110", in_retry); end
        in_valid = 4'b0010;
        #1;
        n_checks++;
        if (in_retry !== 4'b1101) begin n_errors++; $display("FAIL ar_grant1: got %b expected 1101", in_retry); end
        step();
        in_valid = '0;
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== 64'h401) begin
            n_errors++;
            $display("FAIL ar_out: got v=%b src=%0d data=%h expected v=1 src=1 data=401", out_valid, out_src, out_data);
        end
        step();
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_retry = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
